// File: rtl/alarm_zone_controller_if.sv
// Keypad/sensor/configuration inputs and status outputs of the zone alarm controller.
interface alarm_zone_controller_if #(
  parameter int N_ZONES = 4
);
  logic [1:0]         KEY_STATUS;
  logic [N_ZONES-1:0] SENSOR_IN;
  logic [N_ZONES-1:0] ZONE_EN;
  logic [N_ZONES-1:0] ZONE_DELAYED;
  logic [2:0]         STATE_OUT;
  logic               ARMED_OUT;
  logic               SIREN_OUT;
  logic               TIMER_BUSY;
  logic [N_ZONES-1:0] ALARM_ZONES;

  modport master (
    output KEY_STATUS, SENSOR_IN, ZONE_EN, ZONE_DELAYED,
    input  STATE_OUT, ARMED_OUT, SIREN_OUT, TIMER_BUSY, ALARM_ZONES
  );

  modport slave (
    input  KEY_STATUS, SENSOR_IN, ZONE_EN, ZONE_DELAYED,
    output STATE_OUT, ARMED_OUT, SIREN_OUT, TIMER_BUSY, ALARM_ZONES
  );
endinterface

// File: rtl/alarm_zone_controller.sv
// Multi-zone alarm controller: exit/entry delays, siren auto-silence and a latched
// alarm-memory word, all sharing one down-counter.
module alarm_zone_controller #(
  parameter int N_ZONES     = 4,
  parameter int CNT_W       = 20,
  parameter int EXIT_DELAY  = 150000,
  parameter int ENTRY_DELAY = 150000,
  parameter int SIREN_TIME  = 600000
) (
  input  logic                      SERCLK_OUT,
  input  logic                      RESET_IN,
  alarm_zone_controller_if.slave    io
);

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_t;

  // A state entered with load D-1 leaves after exactly D cycles.
  localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_DELAY - 1);
  localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] SIREN_LOAD = CNT_W'(SIREN_TIME - 1);

  logic [N_ZONES-1:0] sync1_r;
  logic [N_ZONES-1:0] sync2_r;
  logic [N_ZONES-1:0] zones_s;
  logic [N_ZONES-1:0] new_zones_s;
  logic [N_ZONES-1:0] alarm_zones_r;
  logic [N_ZONES-1:0] alarm_zones_nx_s;
  state_t             state_r;
  state_t             state_nx_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_nx_s;
  logic [CNT_W-1:0]   cnt_dec_s;
  logic               silenced_r;
  logic               silenced_nx_s;
  logic               inst_s;
  logic               dly_s;
  logic               key_ok_s;
  logic               key_err_s;
  logic               cnt_zero_s;
  logic               armed_r;
  logic               siren_r;
  logic               busy_r;

  // Two-flop synchroniser for the asynchronous zone inputs
  always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
    if (RESET_IN) begin
      sync1_r <= {N_ZONES{1'b0}};
      sync2_r <= {N_ZONES{1'b0}};
    end else begin
      sync1_r <= io.SENSOR_IN;
      sync2_r <= sync1_r;
    end
  end

  assign zones_s     = sync2_r & io.ZONE_EN;
  assign inst_s      = |(zones_s & ~io.ZONE_DELAYED);
  assign dly_s       = |(zones_s & io.ZONE_DELAYED);
  assign new_zones_s = zones_s & ~alarm_zones_r;
  // Reserved code 1 falls through both decodes and therefore acts as NO_KEY.
  assign key_ok_s    = (io.KEY_STATUS == 2'd0);
  assign key_err_s   = (io.KEY_STATUS == 2'd2);
  assign cnt_zero_s  = (cnt_r == {CNT_W{1'b0}});
  assign cnt_dec_s   = cnt_r - CNT_W'(1);

  // Next-state, counter, silence flag and alarm-memory update
  always_comb begin
    state_nx_s       = state_r;
    cnt_nx_s         = cnt_r;
    silenced_nx_s    = silenced_r;
    alarm_zones_nx_s = alarm_zones_r;
    case (state_r)
      ST_DISARMED: begin
        if (key_ok_s) begin
          state_nx_s       = ST_EXIT;
          cnt_nx_s         = EXIT_LOAD;
          alarm_zones_nx_s = {N_ZONES{1'b0}};
        end else begin
          state_nx_s = ST_DISARMED;
        end
      end
      ST_EXIT: begin
        if (key_ok_s) begin
          state_nx_s = ST_DISARMED;
        end else if (cnt_zero_s) begin
          state_nx_s = ST_ARMED;
        end else begin
          cnt_nx_s = cnt_dec_s;
        end
      end
      ST_ARMED: begin
        alarm_zones_nx_s = alarm_zones_r | zones_s;
        if (key_ok_s) begin
          state_nx_s = ST_DISARMED;
        end else if (key_err_s || inst_s) begin
          state_nx_s    = ST_ALARM;
          cnt_nx_s      = SIREN_LOAD;
          silenced_nx_s = 1'b0;
        end else if (dly_s) begin
          state_nx_s = ST_ENTRY;
          cnt_nx_s   = ENTRY_LOAD;
        end else begin
          state_nx_s = ST_ARMED;
        end
      end
      ST_ENTRY: begin
        // Further delayed trips only update the memory; the running delay is kept.
        alarm_zones_nx_s = alarm_zones_r | zones_s;
        if (key_ok_s) begin
          state_nx_s = ST_DISARMED;
        end else if (key_err_s || inst_s || cnt_zero_s) begin
          state_nx_s    = ST_ALARM;
          cnt_nx_s      = SIREN_LOAD;
          silenced_nx_s = 1'b0;
        end else begin
          cnt_nx_s = cnt_dec_s;
        end
      end
      ST_ALARM: begin
        alarm_zones_nx_s = alarm_zones_r | zones_s;
        if (key_ok_s) begin
          state_nx_s = ST_DISARMED;
        end else if (|new_zones_s) begin
          cnt_nx_s      = SIREN_LOAD;
          silenced_nx_s = 1'b0;
        end else if (cnt_zero_s) begin
          silenced_nx_s = 1'b1;
        end else begin
          cnt_nx_s = cnt_dec_s;
        end
      end
      default: begin
        state_nx_s    = ST_DISARMED;
        cnt_nx_s      = {CNT_W{1'b0}};
        silenced_nx_s = 1'b0;
      end
    endcase
  end

  // FSM state, shared counter, silence flag and alarm memory
  always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
    if (RESET_IN) begin
      state_r       <= ST_DISARMED;
      cnt_r         <= {CNT_W{1'b0}};
      silenced_r    <= 1'b0;
      alarm_zones_r <= {N_ZONES{1'b0}};
    end else begin
      state_r       <= state_nx_s;
      cnt_r         <= cnt_nx_s;
      silenced_r    <= silenced_nx_s;
      alarm_zones_r <= alarm_zones_nx_s;
    end
  end

  // Status flags registered from the next state so they track state_r exactly
  always_ff @(posedge SERCLK_OUT or posedge RESET_IN) begin
    if (RESET_IN) begin
      armed_r <= 1'b0;
      siren_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      armed_r <= (state_nx_s != ST_DISARMED);
      siren_r <= (state_nx_s == ST_ALARM) && !silenced_nx_s;
      busy_r  <= (state_nx_s == ST_EXIT) || (state_nx_s == ST_ENTRY);
    end
  end

  assign io.STATE_OUT   = state_r;
  assign io.ARMED_OUT   = armed_r;
  assign io.SIREN_OUT   = siren_r;
  assign io.TIMER_BUSY  = busy_r;
  assign io.ALARM_ZONES = alarm_zones_r;

endmodule

// File: tb/tb_alarm_zone_controller.sv
// Directed and randomized bench for alarm_zone_controller against a deadline-based
// behavioural model of the alarm rules.
module tb_alarm_zone_controller;

  localparam int NZ      = 4;
  localparam int CW      = 20;
  localparam int EXIT_D  = 8;
  localparam int ENTRY_D = 5;
  localparam int SIREN_T = 20;

  localparam int M_DIS   = 0;
  localparam int M_EXIT  = 1;
  localparam int M_ARMED = 2;
  localparam int M_ENTRY = 3;
  localparam int M_ALARM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alarm_zone_controller_if #(.N_ZONES(NZ)) io ();

  alarm_zone_controller #(
    .N_ZONES(NZ), .CNT_W(CW), .EXIT_DELAY(EXIT_D),
    .ENTRY_DELAY(ENTRY_D), .SIREN_TIME(SIREN_T)
  ) dut (
    .SERCLK_OUT(clk),
    .RESET_IN(rst),
    .io(io)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: mode plus absolute edge deadlines instead of a counter.
  int         ecnt = 0;
  int         m_mode = M_DIS;
  int         m_deadline = 0;
  int         m_siren_end = 0;
  logic [3:0] m_zones = 4'd0;
  logic [3:0] h1 = 4'd0;
  logic [3:0] h2 = 4'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode = M_DIS; m_deadline = 0; m_siren_end = 0;
    m_zones = 4'd0; h1 = 4'd0; h2 = 4'd0;
  endtask

  task automatic model_edge(input logic [1:0] key, input logic [3:0] sens,
                            input logic [3:0] en, input logic [3:0] dcfg);
    logic [3:0] seen;
    logic ok, err, inst, dl, newz;
    seen = h2 & en;          // FSM sees the sample taken two edges earlier
    h2 = h1;
    h1 = sens;
    ok   = (key == 2'd0);
    err  = (key == 2'd2);
    inst = |(seen & ~dcfg);
    dl   = |(seen & dcfg);
    newz = |(seen & ~m_zones);
    if (m_mode == M_ARMED || m_mode == M_ENTRY || m_mode == M_ALARM) m_zones = m_zones | seen;
    if (m_mode == M_DIS) begin
      if (ok) begin m_mode = M_EXIT; m_deadline = ecnt + EXIT_D; m_zones = 4'd0; end
    end else if (m_mode == M_EXIT) begin
      if (ok) m_mode = M_DIS;
      else if (ecnt == m_deadline) m_mode = M_ARMED;
    end else if (m_mode == M_ARMED) begin
      if (ok) m_mode = M_DIS;
      else if (err || inst) begin m_mode = M_ALARM; m_siren_end = ecnt + SIREN_T; end
      else if (dl) begin m_mode = M_ENTRY; m_deadline = ecnt + ENTRY_D; end
    end else if (m_mode == M_ENTRY) begin
      if (ok) m_mode = M_DIS;
      else if (err || inst || ecnt == m_deadline) begin m_mode = M_ALARM; m_siren_end = ecnt + SIREN_T; end
    end else begin
      if (ok) m_mode = M_DIS;
      else if (newz) m_siren_end = ecnt + SIREN_T;
    end
  endtask

  task automatic check_all();
    chk("state", {29'd0, io.STATE_OUT}, m_mode);
    chk("armed", {31'd0, io.ARMED_OUT}, {31'd0, m_mode != M_DIS});
    chk("siren", {31'd0, io.SIREN_OUT}, {31'd0, (m_mode == M_ALARM) && (ecnt < m_siren_end)});
    chk("busy",  {31'd0, io.TIMER_BUSY}, {31'd0, (m_mode == M_EXIT) || (m_mode == M_ENTRY)});
    chk("zones", {28'd0, io.ALARM_ZONES}, {28'd0, m_zones});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, {29'd0, io.STATE_OUT}, 32'd0);
    chk({tag, "_armed"}, {31'd0, io.ARMED_OUT}, 32'd0);
    chk({tag, "_siren"}, {31'd0, io.SIREN_OUT}, 32'd0);
    chk({tag, "_busy"},  {31'd0, io.TIMER_BUSY}, 32'd0);
    chk({tag, "_zones"}, {28'd0, io.ALARM_ZONES}, 32'd0);
  endtask

  task automatic step(input logic [1:0] key, input logic [3:0] sens);
    io.KEY_STATUS = key;
    io.SENSOR_IN  = sens;
    @(posedge clk);
    ecnt++;
    model_edge(key, sens, io.ZONE_EN, io.ZONE_DELAYED);
    #1;
    check_all();
    io.KEY_STATUS = 2'd3;
  endtask

  task automatic do_arm();
    step(2'd0, 4'd0);
    chk("arm_exit", {29'd0, io.STATE_OUT}, 32'd1);
    chk("arm_clear", {28'd0, io.ALARM_ZONES}, 32'd0);
    repeat (EXIT_D) step(2'd3, 4'd0);
    chk("arm_armed", {29'd0, io.STATE_OUT}, 32'd2);
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check_zero(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] key;
    logic [3:0] sens;
    int r;
    io.KEY_STATUS   = 2'd3;
    io.SENSOR_IN    = 4'd0;
    io.ZONE_EN      = 4'b1111;
    io.ZONE_DELAYED = 4'b0001;
    #1 rst = 1'b1;
    #1 check_zero("por");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Arm; an instant-zone trip during EXIT is ignored
    step(2'd0, 4'd0);
    chk("exit_state", {29'd0, io.STATE_OUT}, 32'd1);
    for (int i = 1; i < EXIT_D; i++) begin
      step(2'd3, (i <= 5) ? 4'b0010 : 4'b0000);
      chk("exit_hold", {29'd0, io.STATE_OUT}, 32'd1);
      chk("exit_busy", {31'd0, io.TIMER_BUSY}, 32'd1);
    end
    step(2'd3, 4'd0);
    chk("exit_done", {29'd0, io.STATE_OUT}, 32'd2);
    chk("exit_busy_low", {31'd0, io.TIMER_BUSY}, 32'd0);

    // Delayed zone -> ENTRY on third edge -> ALARM five cycles later
    step(2'd3, 4'b0001);
    step(2'd3, 4'b0001);
    chk("dly_not_yet", {29'd0, io.STATE_OUT}, 32'd2);
    step(2'd3, 4'b0001);
    chk("dly_entry", {29'd0, io.STATE_OUT}, 32'd3);
    repeat (ENTRY_D - 1) step(2'd3, 4'b0001);
    chk("dly_still_entry", {29'd0, io.STATE_OUT}, 32'd3);
    step(2'd3, 4'b0001);
    chk("dly_alarm", {29'd0, io.STATE_OUT}, 32'd4);
    chk("dly_siren", {31'd0, io.SIREN_OUT}, 32'd1);
    chk("dly_zones", {28'd0, io.ALARM_ZONES}, 32'd1);
    step(2'd0, 4'd0);
    chk("dly_disarm", {29'd0, io.STATE_OUT}, 32'd0);

    // Disarm within the entry delay; memory kept until next arming
    do_arm();
    repeat (3) step(2'd3, 4'b0001);
    chk("din_entry", {29'd0, io.STATE_OUT}, 32'd3);
    repeat (2) step(2'd3, 4'b0001);
    step(2'd0, 4'b0001);
    chk("din_disarmed", {29'd0, io.STATE_OUT}, 32'd0);
    chk("din_siren", {31'd0, io.SIREN_OUT}, 32'd0);
    repeat (3) step(2'd3, 4'd0);
    chk("din_mem_kept", {28'd0, io.ALARM_ZONES}, 32'd1);
    do_arm();

    // Instant zone
    repeat (3) step(2'd3, 4'b0100);
    chk("inst_alarm", {29'd0, io.STATE_OUT}, 32'd4);
    chk("inst_zones", {28'd0, io.ALARM_ZONES}, 32'd4);
    step(2'd0, 4'd0);

    // KEY_ERROR acts on the same edge
    do_arm();
    step(2'd2, 4'd0);
    chk("kerr_alarm", {29'd0, io.STATE_OUT}, 32'd4);
    step(2'd0, 4'd0);

    // Disabled zone ignored; reserved key code behaves as NO_KEY
    do_arm();
    io.ZONE_EN = 4'b1011;
    repeat (4) step(2'd3, 4'b0100);
    chk("zen_armed", {29'd0, io.STATE_OUT}, 32'd2);
    repeat (3) step(2'd3, 4'd0);
    io.ZONE_EN = 4'b1111;
    step(2'd1, 4'd0);
    chk("key1_armed", {29'd0, io.STATE_OUT}, 32'd2);

    // Siren auto-silence and re-trigger by a new zone
    step(2'd2, 4'd0);
    chk("sir_on", {31'd0, io.SIREN_OUT}, 32'd1);
    repeat (SIREN_T - 1) step(2'd3, 4'd0);
    chk("sir_last", {31'd0, io.SIREN_OUT}, 32'd1);
    step(2'd3, 4'd0);
    chk("sir_off", {31'd0, io.SIREN_OUT}, 32'd0);
    chk("sir_state", {29'd0, io.STATE_OUT}, 32'd4);
    repeat (3) step(2'd3, 4'd0);
    repeat (3) step(2'd3, 4'b1000);
    chk("sir_retrig", {31'd0, io.SIREN_OUT}, 32'd1);
    chk("sir_zone3", {28'd0, io.ALARM_ZONES}, 32'd8);
    repeat (SIREN_T - 1) step(2'd3, 4'b1000);
    chk("sir_retrig_last", {31'd0, io.SIREN_OUT}, 32'd1);
    step(2'd3, 4'b1000);
    chk("sir_retrig_off", {31'd0, io.SIREN_OUT}, 32'd0);
    step(2'd0, 4'd0);
    chk("sir_disarm", {29'd0, io.STATE_OUT}, 32'd0);

    // Asynchronous reset mid-ENTRY
    do_arm();
    repeat (3) step(2'd3, 4'b0001);
    step(2'd3, 4'd0);
    chk("rst_pre_entry", {29'd0, io.STATE_OUT}, 32'd3);
    do_reset("rst_entry");
    step(2'd0, 4'd0);
    chk("rst_first_edge", {29'd0, io.STATE_OUT}, 32'd1);

    // Randomized traffic against the model
    sens = 4'd0;
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      key = (r < 3) ? 2'd0 : (r < 6) ? 2'd2 : (r < 8) ? 2'd1 : 2'd3;
      if ($urandom_range(0, 19) == 0) sens = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) begin
        io.ZONE_EN      = 4'($urandom_range(0, 15));
        io.ZONE_DELAYED = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
      step(key, sens);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
